// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry. Lookup is combinational from PC_F. The entry index
//   comes either straight from the PC (bimodal) or from the PC XORed with
//   a global history register (gshare). The block also counts mispredictions.
//
// Ports
//   CLOCK          clock; all state updates on the rising edge
//   RESET          asynchronous, active-high reset
//   PC_F           fetch PC to predict
//   PredHit_F      lookup entry is valid and its tag matches
//   PredTaken_F    branch predicted taken
//   PredTarget_F   predicted next PC (entry target, or PC_F+4)
//   UpdEN          a resolved-branch update is present this cycle
//   UpdPC          PC of the resolved branch
//   UpdTaken       resolved direction
//   UpdTarget      resolved taken target
//   UpdMispredict  the pipeline flushed for this branch
//   MissCount      saturating count of mispredictions
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned MODE    = 0,
  parameter int unsigned HIST_W  = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [31:0]      PC_F,
  output logic             PredHit_F,
  output logic             PredTaken_F,
  output logic [31:0]      PredTarget_F,
  input  logic             UpdEN,
  input  logic [31:0]      UpdPC,
  input  logic             UpdTaken,
  input  logic [31:0]      UpdTarget,
  input  logic             UpdMispredict,
  output logic [CNT_W-1:0] MissCount
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];
  logic [HIST_W-1:0]  r_ghr;
  logic [CNT_W-1:0]   r_miss;

  logic [IDX_W-1:0]   w_hist;
  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic               w_lk_hit;
  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_up_hit;
  logic               w_unused;

  // PC bits [1:0] never take part in indexing or tagging.
  assign w_unused = ^{PC_F[1:0], UpdPC[1:0]};

  // History is zero-extended into the index so it only disturbs the low
  // HIST_W bits; bimodal mode ignores it entirely.
  assign w_hist   = (MODE == 1) ? IDX_W'(r_ghr) : '0;

  assign w_lk_idx = PC_F[IDX_W+1:2] ^ w_hist;
  assign w_lk_tag = PC_F[31:IDX_W+2];
  assign w_up_idx = UpdPC[IDX_W+1:2] ^ w_hist;
  assign w_up_tag = UpdPC[31:IDX_W+2];

  // Lookup reads pre-edge state, so a same-cycle update becomes visible
  // only from the following cycle.
  assign w_lk_hit = !RESET && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  assign PredHit_F    = w_lk_hit;
  assign PredTaken_F  = w_lk_hit && r_cnt[w_lk_idx][1];
  assign PredTarget_F = PredTaken_F ? r_target[w_lk_idx] : (PC_F + 32'd4);
  assign MissCount    = r_miss;

  // Valid bits, counters, history and miss count carry a reset value.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= 2'b01;
      end
      r_ghr  <= '0;
      r_miss <= '0;
    end else if (UpdEN) begin
      r_ghr <= HIST_W'({r_ghr, UpdTaken});
      if (UpdMispredict && (r_miss != '1)) begin
        r_miss <= r_miss + 1'b1;
      end
      if (w_up_hit) begin
        if (UpdTaken && (r_cnt[w_up_idx] != 2'b11)) begin
          r_cnt[w_up_idx] <= r_cnt[w_up_idx] + 2'b01;
        end else if (!UpdTaken && (r_cnt[w_up_idx] != 2'b00)) begin
          r_cnt[w_up_idx] <= r_cnt[w_up_idx] - 2'b01;
        end
      end else if (UpdTaken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_cnt[w_up_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target storage needs no reset: it is qualified by r_valid.
  always_ff @(posedge CLOCK) begin
    if (!RESET && UpdEN && UpdTaken) begin
      r_target[w_up_idx] <= UpdTarget;
      if (!w_up_hit) begin
        r_tag[w_up_idx] <= w_up_tag;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  int          checks;
  int          errors;

  // Instance A: bimodal, default sizes
  logic        rst_a;
  logic [31:0] pc_a;
  logic        hit_a, taken_a;
  logic [31:0] tgt_a;
  logic        en_a, utk_a, mis_a;
  logic [31:0] upc_a, utg_a;
  logic [15:0] cnt_a;

  // Instance B: gshare, HIST_W=2, CNT_W=2
  logic        rst_b;
  logic [31:0] pc_b;
  logic        hit_b, taken_b;
  logic [31:0] tgt_b;
  logic        en_b, utk_b, mis_b;
  logic [31:0] upc_b, utg_b;
  logic [1:0]  cnt_b;

  branch_predictor #(.ENTRIES(16), .MODE(0), .HIST_W(4), .CNT_W(16)) u_a (
    .CLOCK(clk), .RESET(rst_a), .PC_F(pc_a),
    .PredHit_F(hit_a), .PredTaken_F(taken_a), .PredTarget_F(tgt_a),
    .UpdEN(en_a), .UpdPC(upc_a), .UpdTaken(utk_a), .UpdTarget(utg_a),
    .UpdMispredict(mis_a), .MissCount(cnt_a)
  );

  branch_predictor #(.ENTRIES(16), .MODE(1), .HIST_W(2), .CNT_W(2)) u_b (
    .CLOCK(clk), .RESET(rst_b), .PC_F(pc_b),
    .PredHit_F(hit_b), .PredTaken_F(taken_b), .PredTarget_F(tgt_b),
    .UpdEN(en_b), .UpdPC(upc_b), .UpdTaken(utk_b), .UpdTarget(utg_b),
    .UpdMispredict(mis_b), .MissCount(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd_a(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    en_a = 1'b1; upc_a = pc; utk_a = tk; utg_a = tg; mis_a = 1'b0;
    tick();
    en_a = 1'b0;
  endtask

  task automatic look_a(input string name, input logic [31:0] pc, input logic eh,
                        input logic et, input logic [31:0] etg);
    pc_a = pc;
    #1;
    checks++;
    if (hit_a !== eh || taken_a !== et || tgt_a !== etg) begin
      errors++;
      $display("FAIL %s: hit=%b taken=%b target=%h, expected hit=%b taken=%b target=%h",
               name, hit_a, taken_a, tgt_a, eh, et, etg);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    pc_a = 32'h40; pc_b = 32'h40;
    en_a = 1'b1; upc_a = 32'h40; utk_a = 1'b1; utg_a = 32'h100; mis_a = 1'b1;
    en_b = 1'b0; upc_b = '0; utk_b = 1'b0; utg_b = '0; mis_b = 1'b0;
    #2;
    look_a("reset_lookup", 32'h40, 1'b0, 1'b0, 32'h44);
    tick(); tick();
    look_a("reset_upd_ignored", 32'h40, 1'b0, 1'b0, 32'h44);
    checks++;
    if (cnt_a !== 16'd0) begin
      errors++; $display("FAIL reset_misscount: got %0d expected 0", cnt_a);
    end
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; mis_a = 1'b0;
    look_a("post_reset_lookup", 32'h40, 1'b0, 1'b0, 32'h44);
    checks++;
    if (cnt_a !== 16'd0 || cnt_b !== 2'd0) begin
      errors++; $display("FAIL post_reset_misscount: got %0d/%0d expected 0/0", cnt_a, cnt_b);
    end
  endtask

  task automatic test_counter();
    upd_a(32'h40, 1'b1, 32'h100);
    look_a("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    upd_a(32'h40, 1'b0, 32'h0);
    look_a("ctr_01", 32'h40, 1'b1, 1'b0, 32'h44);
    upd_a(32'h40, 1'b0, 32'h0);
    look_a("ctr_00", 32'h40, 1'b1, 1'b0, 32'h44);
    for (int i = 0; i < 3; i++) upd_a(32'h40, 1'b0, 32'h0);
    upd_a(32'h40, 1'b1, 32'h100);
    look_a("ctr_sat_low_then_01", 32'h40, 1'b1, 1'b0, 32'h44);
    upd_a(32'h40, 1'b1, 32'h180);
    look_a("ctr_10_new_target", 32'h40, 1'b1, 1'b1, 32'h180);
    for (int i = 0; i < 3; i++) upd_a(32'h40, 1'b1, 32'h180);
    upd_a(32'h40, 1'b0, 32'h0);
    look_a("ctr_sat_high", 32'h40, 1'b1, 1'b1, 32'h180);
  endtask

  task automatic test_alias();
    look_a("alias_miss", 32'h440, 1'b0, 1'b0, 32'h444);
    upd_a(32'h440, 1'b1, 32'h200);
    look_a("alias_replaced", 32'h440, 1'b1, 1'b1, 32'h200);
    look_a("alias_old_gone", 32'h40, 1'b0, 1'b0, 32'h44);
  endtask

  task automatic test_same_cycle();
    pc_a = 32'h80;
    en_a = 1'b1; upc_a = 32'h80; utk_a = 1'b1; utg_a = 32'h300; mis_a = 1'b0;
    look_a("same_cycle_pre", 32'h80, 1'b0, 1'b0, 32'h84);
    tick();
    en_a = 1'b0;
    look_a("same_cycle_post", 32'h80, 1'b1, 1'b1, 32'h300);
  endtask

  task automatic test_ignored_updates();
    upd_a(32'hC0, 1'b0, 32'h0);
    look_a("nt_miss_no_alloc", 32'hC0, 1'b0, 1'b0, 32'hC4);
    look_a("nt_miss_keeps_entry", 32'h80, 1'b1, 1'b1, 32'h300);
    en_a = 1'b0; upc_a = 32'h100; utk_a = 1'b1; utg_a = 32'h900; mis_a = 1'b1;
    tick();
    look_a("en0_no_alloc", 32'h100, 1'b0, 1'b0, 32'h104);
    look_a("en0_keeps_entry", 32'h80, 1'b1, 1'b1, 32'h300);
    checks++;
    if (cnt_a !== 16'd0) begin
      errors++; $display("FAIL en0_misscount: got %0d expected 0", cnt_a);
    end
    en_a = 1'b1; upc_a = 32'hF00; utk_a = 1'b0; mis_a = 1'b1;
    tick();
    en_a = 1'b0; mis_a = 1'b0;
    checks++;
    if (cnt_a !== 16'd1) begin
      errors++; $display("FAIL misscount_a: got %0d expected 1", cnt_a);
    end
  endtask

  task automatic test_gshare();
    // GHR 00: 0x48 -> index 2, tag 1
    en_b = 1'b1; upc_b = 32'h48; utk_b = 1'b1; utg_b = 32'h500; mis_b = 1'b0;
    tick();
    // GHR 01: 0x80C -> index 3^1=2, tag 0x20 misses, not taken: no change
    upc_b = 32'h80C; utk_b = 1'b0; utg_b = 32'h0;
    tick();
    en_b = 1'b0;
    // GHR now 10: 0x40 -> index 0^2=2, tag 1 hits the 0x48 allocation
    pc_b = 32'h40; #1;
    checks++;
    if (hit_b !== 1'b1 || taken_b !== 1'b1 || tgt_b !== 32'h500) begin
      errors++;
      $display("FAIL gshare_idx2: hit=%b taken=%b target=%h expected 1 1 00000500", hit_b, taken_b, tgt_b);
    end
    pc_b = 32'h48; #1;
    checks++;
    if (hit_b !== 1'b0 || tgt_b !== 32'h4C) begin
      errors++;
      $display("FAIL gshare_idx0: hit=%b target=%h expected 0 0000004c", hit_b, tgt_b);
    end
  endtask

  task automatic test_misscount();
    logic [1:0] exp_cnt [4];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
    en_b = 1'b1; upc_b = 32'hF00; utk_b = 1'b0; utg_b = 32'h0; mis_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (cnt_b !== exp_cnt[i]) begin
        errors++; $display("FAIL misscount_%0d: got %0d expected %0d", i, cnt_b, exp_cnt[i]);
      end
    end
    en_b = 1'b0; mis_b = 1'b0;
    // Four not-taken shifts leave GHR=00, so 0x48 maps back to index 2.
    pc_b = 32'h48; #1;
    checks++;
    if (hit_b !== 1'b1) begin
      errors++; $display("FAIL pre_async_hit: got %b expected 1", hit_b);
    end
    #2;
    rst_b = 1'b1;
    #1;
    checks++;
    if (cnt_b !== 2'd0 || hit_b !== 1'b0 || taken_b !== 1'b0 || tgt_b !== 32'h4C) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d hit=%b taken=%b target=%h expected 0 0 0 0000004c",
               cnt_b, hit_b, taken_b, tgt_b);
    end
    tick();
    rst_b = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_counter();
    test_alias();
    test_same_cycle();
    test_ignored_updates();
    test_gshare();
    test_misscount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
